code_verifier: RTL and testbench

Digit-entry verification engine for the digital lock. It buffers up to 8 entered digits with a saturating write index. On submit, it reads the buffer back one digit per cycle and compares each against the secret code. It then drives unlock, fail and lockout status to the panel/actuator logic, and enforces a failed-attempt lockout window.

---
 rtl/code_verifier.sv | 152 +++++++++++++++
 tb/tb_code_verifier.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_verifier.sv
// Digit-entry verification engine: buffers up to 8 digits, compares them against the secret code
// in constant time, and enforces a lockout after repeated failures. Optional macro: CODE_VERIFIER_AUTORELOCK_EN.
module code_verifier #(
    parameter int CODE_LEN          = 4,
    parameter int MAX_FAILS         = 3,
    parameter int LOCKOUT_CYCLES    = 1000,
    parameter int AUTORELOCK_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        submit,
    input  logic        clear,
    input  logic [31:0] secret,
    output logic [3:0]  entry_count,
    output logic        busy,
    output logic        unlocked,
    output logic        fail_pulse,
    output logic        locked_out
);

    localparam int              LT_W      = $clog2(LOCKOUT_CYCLES) + 1;
    localparam logic [LT_W-1:0] LOCK_LAST = LT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]      LEN_Q     = 4'(CODE_LEN);
    localparam logic [2:0]      LAST_IDX  = 3'(CODE_LEN - 1);
    localparam logic [3:0]      FAIL_LIM  = 4'(MAX_FAILS);

`ifdef CODE_VERIFIER_AUTORELOCK_EN
    localparam int              AT_W    = $clog2(AUTORELOCK_CYCLES) + 1;
    localparam logic [AT_W-1:0] AR_LAST = AT_W'(AUTORELOCK_CYCLES - 1);
    logic [AT_W-1:0] pass_tmr;
`else
    logic unused_autorelock;
    assign unused_autorelock = ^{1'b0, 32'(AUTORELOCK_CYCLES)};
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_PASS,
        S_FAIL,
        S_LOCKOUT
    } state_t;

    state_t          state;
    logic [3:0]      dbuf [8];
    logic [2:0]      rd_idx;
    logic            mismatch;
    logic [3:0]      fail_cnt;
    logic [LT_W-1:0] lock_tmr;
    logic            digit_miss;
    logic            buf_wr;

    // Status outputs are a registered decode of the state, so they trail it by one cycle.
    function automatic logic [3:0] status_of(input state_t s);
        case (s)
            S_CHECK:   status_of = 4'b1000;
            S_PASS:    status_of = 4'b0100;
            S_FAIL:    status_of = 4'b1010;
            S_LOCKOUT: status_of = 4'b1001;
            default:   status_of = 4'b0000;
        endcase
    endfunction

    assign digit_miss = (dbuf[rd_idx] != secret[{rd_idx, 2'b00} +: 4]);
    assign buf_wr     = (state == S_IDLE) && digit_valid && !submit && !clear
                        && (entry_count != 4'd8);

    always_ff @(posedge clk) begin
        if (buf_wr)
            dbuf[entry_count[2:0]] <= digit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            entry_count <= 4'd0;
            rd_idx      <= 3'd0;
            mismatch    <= 1'b0;
            fail_cnt    <= 4'd0;
            lock_tmr    <= '0;
            {busy, unlocked, fail_pulse, locked_out} <= 4'b0000;
`ifdef CODE_VERIFIER_AUTORELOCK_EN
            pass_tmr    <= '0;
`endif
        end else begin
            {busy, unlocked, fail_pulse, locked_out} <= status_of(state);
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        entry_count <= 4'd0;
                    end else if (submit) begin
                        if (entry_count == LEN_Q) begin
                            state    <= S_CHECK;
                            rd_idx   <= 3'd0;
                            mismatch <= 1'b0;
                        end else if (entry_count != 4'd0) begin
                            state <= S_FAIL;
                        end
                    end else if (buf_wr) begin
                        entry_count <= entry_count + 4'd1;
                    end
                end
                // Every digit is examined regardless of earlier mismatches to keep timing constant.
                S_CHECK: begin
                    mismatch <= mismatch | digit_miss;
                    if (rd_idx == LAST_IDX) begin
                        if (mismatch | digit_miss) begin
                            state <= S_FAIL;
                        end else begin
                            state       <= S_PASS;
                            entry_count <= 4'd0;
                        end
                    end else begin
                        rd_idx <= rd_idx + 3'd1;
                    end
                end
                S_PASS: begin
                    fail_cnt <= 4'd0;
`ifdef CODE_VERIFIER_AUTORELOCK_EN
                    if (clear || (pass_tmr == AR_LAST)) begin
                        state    <= S_IDLE;
                        pass_tmr <= '0;
                    end else begin
                        pass_tmr <= pass_tmr + AT_W'(1);
                    end
`else
                    if (clear)
                        state <= S_IDLE;
`endif
                end
                S_FAIL: begin
                    entry_count <= 4'd0;
                    fail_cnt    <= fail_cnt + 4'd1;
                    state       <= ((fail_cnt + 4'd1) == FAIL_LIM) ? S_LOCKOUT : S_IDLE;
                end
                S_LOCKOUT: begin
                    if (lock_tmr == LOCK_LAST) begin
                        state    <= S_IDLE;
                        lock_tmr <= '0;
                        fail_cnt <= 4'd0;
                    end else begin
                        lock_tmr <= lock_tmr + LT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_code_verifier.sv
// Directed bench for code_verifier: secret 1,2,3,4, CODE_LEN=4, MAX_FAILS=3, LOCKOUT_CYCLES=16.
module tb_code_verifier;

    localparam int CODE_LEN          = 4;
    localparam int MAX_FAILS         = 3;
    localparam int LOCKOUT_CYCLES    = 16;
    localparam int AUTORELOCK_CYCLES = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        submit = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] secret = 32'h0000_4321;
    logic [3:0]  entry_count;
    logic        busy;
    logic        unlocked;
    logic        fail_pulse;
    logic        locked_out;

    int n_checks = 0;
    int n_fail   = 0;

    code_verifier #(
        .CODE_LEN(CODE_LEN),
        .MAX_FAILS(MAX_FAILS),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
        .AUTORELOCK_CYCLES(AUTORELOCK_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .digit_valid(digit_valid),
        .digit(digit),
        .submit(submit),
        .clear(clear),
        .secret(secret),
        .entry_count(entry_count),
        .busy(busy),
        .unlocked(unlocked),
        .fail_pulse(fail_pulse),
        .locked_out(locked_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; digit_valid = 1'b0; submit = 1'b0; clear = 1'b0; digit = 4'd0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic enter_digit(input logic [3:0] d);
        digit = d; digit_valid = 1'b1;
        tick;
        digit_valid = 1'b0;
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        enter_digit(a); enter_digit(b); enter_digit(c); enter_digit(d);
    endtask

    task automatic do_submit;
        submit = 1'b1;
        tick;
        submit = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_checks++;
        if ({entry_count, busy, unlocked, fail_pulse, locked_out} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got cnt=%0d busy=%b unl=%b fp=%b lo=%b, expected all 0",
                     entry_count, busy, unlocked, fail_pulse, locked_out);
        end
    endtask

    task automatic test_correct_code;
        do_reset;
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        n_checks++;
        if (entry_count !== 4'd4) begin
            n_fail++; $display("FAIL correct_entry_count: got %0d expected 4", entry_count);
        end
        do_submit;
        for (int k = 1; k <= 4; k++) begin
            tick;
            n_checks++;
            if ({busy, unlocked, fail_pulse} !== 3'b100) begin
                n_fail++;
                $display("FAIL correct_check_cycle%0d: got busy/unl/fp=%b%b%b expected 100", k, busy, unlocked, fail_pulse);
            end
        end
        tick;
        n_checks++;
        if ({busy, unlocked, fail_pulse} !== 3'b010) begin
            n_fail++;
            $display("FAIL correct_unlock: got busy/unl/fp=%b%b%b expected 010", busy, unlocked, fail_pulse);
        end
        n_checks++;
        if (entry_count !== 4'd0) begin
            n_fail++; $display("FAIL correct_count_cleared: got %0d expected 0", entry_count);
        end
`ifndef CODE_VERIFIER_AUTORELOCK_EN
        repeat (20) tick;
        n_checks++;
        if (unlocked !== 1'b1) begin
            n_fail++; $display("FAIL correct_unlock_hold: got %b expected 1", unlocked);
        end
`endif
        clear = 1'b1;
        tick;
        clear = 1'b0;
        tick;
        n_checks++;
        if (unlocked !== 1'b0) begin
            n_fail++; $display("FAIL correct_clear_relock: got %b expected 0", unlocked);
        end
    endtask

    task automatic test_last_digit_mismatch;
        do_reset;
        enter4(4'd1, 4'd2, 4'd3, 4'd5);
        do_submit;
        for (int k = 1; k <= 4; k++) begin
            tick;
            n_checks++;
            if ({busy, fail_pulse} !== 2'b10) begin
                n_fail++;
                $display("FAIL mismatch_check_cycle%0d: got busy/fp=%b%b expected 10", k, busy, fail_pulse);
            end
        end
        tick;
        n_checks++;
        if ({fail_pulse, unlocked} !== 2'b10) begin
            n_fail++; $display("FAIL mismatch_fail_pulse: got fp/unl=%b%b expected 10", fail_pulse, unlocked);
        end
        n_checks++;
        if (entry_count !== 4'd0) begin
            n_fail++; $display("FAIL mismatch_count_cleared: got %0d expected 0", entry_count);
        end
        tick;
        n_checks++;
        if ({fail_pulse, busy} !== 2'b00) begin
            n_fail++; $display("FAIL mismatch_pulse_width: got fp/busy=%b%b expected 00", fail_pulse, busy);
        end
    endtask

    task automatic test_wrong_length;
        do_reset;
        enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3);
        do_submit;
        n_checks++;
        if (fail_pulse !== 1'b0) begin
            n_fail++; $display("FAIL short_pulse_early: got %b expected 0", fail_pulse);
        end
        tick;
        n_checks++;
        if ({fail_pulse, entry_count} !== {1'b1, 4'd0}) begin
            n_fail++; $display("FAIL short_fail_pulse: got fp=%b cnt=%0d expected fp=1 cnt=0", fail_pulse, entry_count);
        end
        tick;
        n_checks++;
        if (fail_pulse !== 1'b0) begin
            n_fail++; $display("FAIL short_pulse_width: got %b expected 0", fail_pulse);
        end
        do_reset;
        for (int d = 1; d <= 9; d++) enter_digit(4'(d));
        n_checks++;
        if (entry_count !== 4'd8) begin
            n_fail++; $display("FAIL saturate_count: got %0d expected 8", entry_count);
        end
        do_submit;
        tick;
        n_checks++;
        if ({fail_pulse, busy} !== 2'b11) begin
            n_fail++; $display("FAIL saturate_submit_fail: got fp/busy=%b%b expected 11", fail_pulse, busy);
        end
    endtask

    task automatic test_lockout;
        do_reset;
        for (int a = 1; a <= 2; a++) begin
            enter4(4'd9, 4'd9, 4'd9, 4'd9);
            do_submit;
            repeat (5) tick;
            n_checks++;
            if (fail_pulse !== 1'b1) begin
                n_fail++; $display("FAIL lockout_attempt%0d_pulse: got %b expected 1", a, fail_pulse);
            end
            tick;
        end
        enter4(4'd9, 4'd9, 4'd9, 4'd9);
        do_submit;
        repeat (5) tick;
        n_checks++;
        if ({fail_pulse, locked_out} !== 2'b10) begin
            n_fail++; $display("FAIL lockout_third_pulse: got fp/lo=%b%b expected 10", fail_pulse, locked_out);
        end
        for (int i = 1; i <= 16; i++) begin
            case (i)
                1: begin digit = 4'd7; digit_valid = 1'b1; end
                2: clear = 1'b1;
                3, 4, 5, 6: begin digit = 4'(i - 2); digit_valid = 1'b1; end
                7: submit = 1'b1;
                default: ;
            endcase
            tick;
            digit_valid = 1'b0; clear = 1'b0; submit = 1'b0;
            n_checks++;
            if ({locked_out, busy, unlocked, entry_count} !== {3'b110, 4'd0}) begin
                n_fail++;
                $display("FAIL lockout_cycle%0d: got lo/busy/unl=%b%b%b cnt=%0d expected 110 cnt=0",
                         i, locked_out, busy, unlocked, entry_count);
            end
        end
        tick;
        n_checks++;
        if ({locked_out, busy} !== 2'b00) begin
            n_fail++; $display("FAIL lockout_release: got lo/busy=%b%b expected 00", locked_out, busy);
        end
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        do_submit;
        repeat (5) tick;
        n_checks++;
        if (unlocked !== 1'b1) begin
            n_fail++; $display("FAIL lockout_then_unlock: got %b expected 1", unlocked);
        end
    endtask

    task automatic test_priorities;
        do_reset;
        enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3);
        digit = 4'd4; digit_valid = 1'b1; submit = 1'b1;
        tick;
        digit_valid = 1'b0; submit = 1'b0;
        n_checks++;
        if (entry_count !== 4'd3) begin
            n_fail++; $display("FAIL prio_digit_dropped: got cnt=%0d expected 3", entry_count);
        end
        tick;
        n_checks++;
        if (fail_pulse !== 1'b1) begin
            n_fail++; $display("FAIL prio_digit_submit_fail: got %b expected 1", fail_pulse);
        end
        do_reset;
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        clear = 1'b1; submit = 1'b1;
        tick;
        clear = 1'b0; submit = 1'b0;
        n_checks++;
        if (entry_count !== 4'd0) begin
            n_fail++; $display("FAIL prio_clear_count: got %0d expected 0", entry_count);
        end
        tick;
        n_checks++;
        if ({busy, fail_pulse} !== 2'b00) begin
            n_fail++; $display("FAIL prio_clear_no_check: got busy/fp=%b%b expected 00", busy, fail_pulse);
        end
    endtask

    task automatic test_reset_mid_check;
        do_reset;
        enter4(4'd1, 4'd2, 4'd3, 4'd5);
        do_submit;
        tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++;
        if ({entry_count, busy, unlocked, fail_pulse, locked_out} !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_check: got cnt=%0d busy=%b unl=%b fp=%b lo=%b expected all 0",
                     entry_count, busy, unlocked, fail_pulse, locked_out);
        end
        for (int k = 1; k <= 6; k++) begin
            tick;
            n_checks++;
            if ({busy, fail_pulse} !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_mid_check_after%0d: got busy/fp=%b%b expected 00", k, busy, fail_pulse);
            end
        end
    endtask

`ifdef CODE_VERIFIER_AUTORELOCK_EN
    task automatic test_autorelock;
        do_reset;
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        do_submit;
        repeat (5) tick;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (unlocked !== 1'b1) begin
                n_fail++; $display("FAIL autorelock_hold%0d: got %b expected 1", k, unlocked);
            end
            tick;
        end
        n_checks++;
        if ({unlocked, busy} !== 2'b00) begin
            n_fail++; $display("FAIL autorelock_drop: got unl/busy=%b%b expected 00", unlocked, busy);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_correct_code;
        test_last_digit_mismatch;
        test_wrong_length;
        test_lockout;
        test_priorities;
        test_reset_mid_check;
`ifdef CODE_VERIFIER_AUTORELOCK_EN
        test_autorelock;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
